// File: rtl/serial_pkg.sv
// Shared definitions for the byte-serial link (transmitter and receiver):
// default word geometry, idle comma symbol and the receiver alignment states.
package serial_pkg;

    localparam int         WIDTH_DEF      = 8;
    localparam logic [7:0] COMMA_DEF      = 8'hBC;
    localparam int         LOCK_COUNT_DEF = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_e;

endpackage

// File: rtl/sp_shift_reg.sv
// Serial-in shift register plus modulo-WIDTH bit counter for serial_paralelo.
// candidate is the word including the bit being sampled this edge (as LSB).
module sp_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    input  logic             bit_clr,
    output logic [WIDTH-1:0] candidate,
    output logic             word_end
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        sr_d      = {sr_q[WIDTH-2:0], data_in};
        candidate = sr_d;
        word_end  = (bit_cnt_q == CNT_W'(WIDTH - 1));
        if (bit_clr || word_end) begin
            bit_cnt_d = '0;
        end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/serial_paralelo.sv
// Receive end of the byte-serial link: comma alignment, lock and word delivery.
// Optional: define SERIAL_PARALELO_COMMA_CNT_EN to add the comma_count output.
module serial_paralelo
    import serial_pkg::*;
#(
    parameter int               WIDTH      = WIDTH_DEF,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(COMMA_DEF),
    parameter int               LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
`ifdef SERIAL_PARALELO_COMMA_CNT_EN
    output logic [7:0]       comma_count,
`endif
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             byte_strobe,
    output logic             active
);

    localparam int CC_W = $clog2(LOCK_COUNT + 1);

    state_e           state_q, state_d;
    logic [CC_W-1:0]  comma_cnt_q, comma_cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             strobe_q, strobe_d;
    logic [WIDTH-1:0] candidate;
    logic             word_end;
    logic             bit_clr;
    logic             is_comma;
`ifdef SERIAL_PARALELO_COMMA_CNT_EN
    logic [7:0]       comma_count_q, comma_count_d;
`endif

    sp_shift_reg #(.WIDTH(WIDTH)) u_shift (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .bit_clr  (bit_clr),
        .candidate(candidate),
        .word_end (word_end)
    );

    assign is_comma = (candidate == COMMA);

    // NOTE: every always_comb output gets a default first, so no branch can infer a latch.
    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        strobe_d    = 1'b0;
        bit_clr     = 1'b0;
`ifdef SERIAL_PARALELO_COMMA_CNT_EN
        comma_count_d = comma_count_q;
`endif
        case (state_q)
            SEARCH: begin
                // Hold the counter at 0 so the edge after a match starts a fresh word.
                bit_clr = 1'b1;
                if (is_comma) begin
                    comma_cnt_d = CC_W'(1);
                    state_d     = (LOCK_COUNT <= 1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                if (word_end) begin
                    if (is_comma) begin
                        comma_cnt_d = comma_cnt_q + CC_W'(1);
                        if (comma_cnt_q == CC_W'(LOCK_COUNT - 1)) begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        comma_cnt_d = '0;
                        state_d     = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (word_end) begin
                    strobe_d = 1'b1;
                    if (is_comma) begin
                        valid_d = 1'b0;
`ifdef SERIAL_PARALELO_COMMA_CNT_EN
                        if (comma_count_q != 8'hFF) begin
                            comma_count_d = comma_count_q + 8'd1;
                        end
`endif
                    end else begin
                        data_d  = candidate;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q     <= SEARCH;
            comma_cnt_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            strobe_q    <= 1'b0;
`ifdef SERIAL_PARALELO_COMMA_CNT_EN
            comma_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            comma_cnt_q <= comma_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            strobe_q    <= strobe_d;
`ifdef SERIAL_PARALELO_COMMA_CNT_EN
            comma_count_q <= comma_count_d;
`endif
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = (state_q == ACTIVE);
`ifdef SERIAL_PARALELO_COMMA_CNT_EN
    assign comma_count = comma_count_q;
`endif

endmodule
